fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory and downstream of nothing but reset and branch redirects.
- Owns the program counter and drives the 6-bit word address of the combinational instruction ROM.
- Captures each returned word with its PC in a small queue.
- Presents {pc, instr} to decode over a valid/ready handshake.
- A redirect from execute flushes the queue and restarts fetch at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
DEPTH, 2, fetch queue entries (power of two, >=2).
IMEM_AW, 6, instruction memory word-address width.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_a  output  IMEM_AW  word address to instruction memory, = fetch_pc[IMEM_AW+1:2].
imem_rd  input  32  instruction word returned combinationally for imem_a.
redirect_valid  input  1  execute requests a PC change this cycle.
redirect_pc  input  32  target PC; bits [1:0] ignored.
out_valid  output  1  queue head holds a valid instruction.
out_ready  input  1  decode accepts the head this cycle.
out_pc  output  32  PC of head entry.
out_instr  output  32  instruction of head entry.

Behaviour:
- State:
  - fetch_pc: 32-bit register.
  - Queue: DEPTH entries of {pc, instr}, with read pointer, write pointer and count (0..DEPTH).
- Reset (async, rst_n low), effective immediately regardless of clock:
  - fetch_pc=RESET_PC; count=0, pointers=0, all entry storage=0.
  - out_valid=0, out_pc=0, out_instr=0, imem_a=RESET_PC[IMEM_AW+1:2].
- Outputs:
  - out_valid = (count!=0).
  - out_pc/out_instr = entry at read pointer, driven from registers with no combinational path from imem_rd.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count<DEPTH | pop).
  - Simultaneous push and pop when full is legal; count is unchanged.
- On push:
  - Write {fetch_pc, imem_rd} at the write pointer.
  - fetch_pc <= fetch_pc+4, modulo 2^32.
- Redirect has priority over push and pop in the same cycle:
  - count<=0 and pointers<=0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - The head presented that cycle is discarded, even if out_ready=1.
  - No entry is written.
- Latency:
  - Reset release: first entry (RESET_PC) is pushed on the first rising edge after rst_n high, so out_valid=1 one cycle after release.
  - Redirect in cycle N: out_valid=0 in cycle N+1; target appears at the head in cycle N+2.
- Throughput: one instruction per cycle with out_ready held high; no bubbles except after a redirect.
- Backpressure: with out_ready=0, the queue fills to DEPTH, then fetch_pc and imem_a hold. Nothing is dropped or duplicated.
- Wrap-around:
  - imem_a aliases modulo 2^IMEM_AW words (PC 0x100 reads word 0).
  - out_pc keeps the full 32-bit value.
  - PC 0xFFFF_FFFC+4 wraps to 0.
- Pointers wrap modulo DEPTH.
- redirect_pc is sampled only when redirect_valid=1.

Decomposition:
- Package fetch_pkg:
  - constants XLEN=32, INSTR_W=32, default RESET_PC;
  - typedef fetch_entry_t (pc, instr).
- One sub-module, fetch_queue: a generic DEPTH-entry FIFO of fetch_entry_t with synchronous flush, push/pop, count, and async active-low reset.
- fetch_unit keeps the PC logic and push/redirect arbitration.

Test Plan:
All scenarios preload instruction memory with word i = 32'h1000_0000+i.
1. Release reset, out_ready=1 -> out_valid rises one cycle later; out_pc 0x0,0x4,0x8,0xC on consecutive cycles with out_instr 0x10000000..0x10000003, no gaps.
2. out_ready=0 for 5 cycles after reset -> count saturates at 2 (pc 0x0, 0x4); imem_a holds 2. Raise out_ready -> out_pc 0x0,0x4,0x8,... with no duplicates or skips.
3. Queue holding pc 0x8,0xC plus out_ready=1, redirect_valid=1 with redirect_pc=0x40 -> the 0x8 head is discarded; out_valid=0 next cycle; following cycle out_pc=0x40, out_instr=0x10000010, then 0x44.
4. Redirect to 0x43 -> out_pc=0x40, out_instr=0x10000010.
5. Redirect to 0xFC -> out_pc 0xFC (instr 0x1000003F, imem_a=63), then 0x100 with imem_a=0 and instr 0x10000000.
6. Queue full, assert rst_n low mid-cycle -> out_valid=0, out_pc=0, out_instr=0, imem_a=0 before the next edge. Release -> restart from 0x0 as in scenario 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, default reset PC and the fetch queue entry type.
package fetch_pkg;

  localparam int          XLEN             = 32;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries with synchronous flush; head is read
// straight from registered storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // When full, push and pop share a slot; the old head is still read this cycle.
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a combinational ROM and queues
// {pc, instr} pairs for decode; redirects flush the queue and restart fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_a,
  input  logic [31:0]        imem_rd,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr
);

  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   q_count;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;
  logic            q_full;
  logic            pop;
  logic            push;

  assign q_full    = (q_count == CW'(DEPTH));
  assign out_valid = (q_count != '0);
  assign pop       = out_valid & out_ready;
  // Redirect wins: no write, and the presented head is dropped by the flush.
  assign push      = !redirect_valid & (!q_full | pop);

  assign q_push_data.pc    = fetch_pc_q;
  assign q_push_data.instr = imem_rd;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h0000_0003;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (q_push_data),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign imem_a    = fetch_pc_q[IMEM_AW+1:2];
  assign out_pc    = q_head.pc;
  assign out_instr = q_head.instr;

endmodule
